qlm_mult_pipe: RTL

- Parametrised, pipelined successor to the fixed 16-bit registered QLM multiplier top.
- Computes a quantised logarithmic (Mitchell-style) approximate product of two W-bit operands. Mantissas are truncated to Q bits.
- Sits between an operand producer and a result consumer. Both sides use a valid/ready handshake.
- Pipeline depth is configurable and the whole pipeline stalls under backpressure.

---
 rtl/qlm_mult_pipe.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/qlm_mult_pipe.sv
// Pipelined quantised-log (Mitchell) approximate multiplier with valid/ready stall-on-backpressure.
// Build option: define QLM_SIGNED_EN for two's-complement operands and product.
module qlm_mult_pipe #(
   parameter int unsigned W      = 16,
   parameter int unsigned Q      = 8,
   parameter int unsigned STAGES = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [W-1:0]    x,
   input  logic [W-1:0]    y,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*W-1:0]  p
);

   localparam int unsigned PW = 2 * W;
   localparam int unsigned KW = $clog2(2 * W);

   logic          adv;
   logic [W-1:0]  mag_x;
   logic [W-1:0]  mag_y;
   logic          neg_c;
   logic [KW-1:0] kx_c;
   logic [KW-1:0] ky_c;

   // Every stage moves together whenever the output slot is free or being consumed.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

`ifdef QLM_SIGNED_EN
   assign mag_x = x[W-1] ? W'(~x + W'(1)) : x;
   assign mag_y = y[W-1] ? W'(~y + W'(1)) : y;
   assign neg_c = x[W-1] ^ y[W-1];
`else
   assign mag_x = x;
   assign mag_y = y;
   assign neg_c = 1'b0;
`endif

   function automatic logic [KW-1:0] lead_one(input logic [W-1:0] v);
      lead_one = '0;
      for (int i = 0; i < int'(W); i++)
         if (v[i]) lead_one = KW'(i);
   endfunction

   // Left-align the bits below the leading one and keep the top Q of them.
   function automatic logic [Q-1:0] frac(input logic [W-1:0] v, input logic [KW-1:0] k);
      logic [W-1:0] n;
      n = v << (KW'(W - 1) - k);
      return n[W-2 -: Q];
   endfunction

   function automatic logic [PW-1:0] scale(input logic [Q:0] m, input logic [KW-1:0] e,
                                           input logic z, input logic n);
      logic [PW+Q-1:0] w;
      logic [PW-1:0]   r;
      w = (PW+Q)'(m) << e;
      r = w[PW+Q-1:Q];
      if (z)
         r = '0;
      else if (n)
         r = PW'(~r + PW'(1));
      return r;
   endfunction

   assign kx_c = lead_one(mag_x);
   assign ky_c = lead_one(mag_y);

   // Stage 1: leading-one detect and fraction extract.
   logic          v1;
   logic          z1;
   logic          n1;
   logic [KW-1:0] ksum1;
   logic [Q-1:0]  fx1;
   logic [Q-1:0]  fy1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         z1    <= 1'b0;
         n1    <= 1'b0;
         ksum1 <= '0;
         fx1   <= '0;
         fy1   <= '0;
      end else if (adv) begin
         v1    <= in_valid;
         z1    <= (mag_x == '0) || (mag_y == '0);
         n1    <= neg_c;
         ksum1 <= kx_c + ky_c;
         fx1   <= frac(mag_x, kx_c);
         fy1   <= frac(mag_y, ky_c);
      end
   end

   // Fraction sum; a carry out means the mantissa already includes the implicit one.
   logic [Q:0]    s_c;
   logic [Q:0]    m_c;
   logic [KW-1:0] e_c;

   assign s_c = {1'b0, fx1} + {1'b0, fy1};
   assign m_c = s_c[Q] ? s_c : {1'b1, s_c[Q-1:0]};
   assign e_c = ksum1 + KW'(s_c[Q]);

   logic          v_q;
   logic [PW-1:0] p_q;

   generate
      if (STAGES == 2) begin : g_two
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_q <= 1'b0;
               p_q <= '0;
            end else if (adv) begin
               v_q <= v1;
               p_q <= scale(m_c, e_c, z1, n1);
            end
         end
      end else begin : g_deep
         localparam int unsigned NR = STAGES - 2;
         logic          v2;
         logic          z2;
         logic          n2;
         logic [Q:0]    m2;
         logic [KW-1:0] e2;
         logic          vr [NR];
         logic [PW-1:0] pr [NR];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v2 <= 1'b0;
               z2 <= 1'b0;
               n2 <= 1'b0;
               m2 <= '0;
               e2 <= '0;
            end else if (adv) begin
               v2 <= v1;
               z2 <= z1;
               n2 <= n1;
               m2 <= m_c;
               e2 <= e_c;
            end
         end

         // Shift stage followed by any extra delay registers ahead of the output.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < int'(NR); i++) begin
                  vr[i] <= 1'b0;
                  pr[i] <= '0;
               end
            end else if (adv) begin
               vr[0] <= v2;
               pr[0] <= scale(m2, e2, z2, n2);
               for (int i = 1; i < int'(NR); i++) begin
                  vr[i] <= vr[i-1];
                  pr[i] <= pr[i-1];
               end
            end
         end

         assign v_q = vr[NR-1];
         assign p_q = pr[NR-1];
      end
   endgenerate

   assign out_valid = v_q;
   assign p         = p_q;

endmodule
